queue_write_arbiter: RTL and testbench
======================================

Name: queue_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's FIFO queue between num_req independent producers.
- Grants one producer at a time for a bounded burst of words, forwards that producer's data to the queue's write_cmd/write_data, and honours the queue's full flag.
- Sits between producer blocks and the queue. The queue's read side is untouched.

Parameters:
- data_width, 4, bits per data word; must match the queue.
- num_req, 4, number of requesters, 2..8.
- req_id_width, 2, width of grant_id; equals clog2(num_req).
- max_burst, 4, maximum words accepted per grant, 1..15.
- count_width, 4, width of the burst beat counter; must hold max_burst-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  num_req  per-requester request; held high while the requester has a word on its req_data slice.
- req_data  input  num_req*data_width  flattened producer data; slice i is bits [i*data_width +: data_width].
- ack  output  num_req  one-hot, combinational; ack[i]=1 means slice i was written into the queue this cycle.
- full  input  1  queue full flag.
- write_cmd  output  1  queue write command, combinational.
- write_data  output  data_width  queue write data, combinational; equals slice grant_id.
- grant_valid  output  1  registered; 1 while in BURST.
- grant_id  output  req_id_width  registered index of the current owner.

Behaviour:
- Reset (synchronous, checked at posedge clk with highest priority):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_count=0, grant_valid=0.
  - Outputs settle to write_cmd=0 and ack=0.
- Reset asserted mid-burst aborts the grant in the same edge. A word accepted in that cycle is still counted by the queue, so the producer must see its ack.
- State IDLE:
  - write_cmd=0, ack=0, write_data=slice grant_id (don't-care).
  - If any req bit is high, select the first index i scanning rr_ptr, rr_ptr+1, ... mod num_req with req[i]=1.
  - Next edge: grant_id<=i, beat_count<=0, state<=BURST.
  - full does not block arbitration.
  - Arbitration costs exactly one idle cycle per grant.
- State BURST:
  - write_cmd = req[grant_id] & ~full.
  - ack[grant_id] = write_cmd; all other ack bits are 0.
  - On accept (write_cmd=1) with beat_count==max_burst-1: state<=IDLE, rr_ptr<=grant_id+1 mod num_req.
  - On accept otherwise: beat_count<=beat_count+1.
  - If req[grant_id]=0 (owner released): no write, state<=IDLE, rr_ptr<=grant_id+1 mod num_req.
  - If full=1 and req[grant_id]=1: stall; hold state, owner and beat_count. No timeout.
- Other requesters' req may change freely without effect during BURST.
- Pointer wrap: rr_ptr wraps from num_req-1 to 0.
- Fairness: a requester asserting req continuously is granted within num_req-1 other grants.
- A sole requester is re-granted after one IDLE cycle.
- Producer rule: req_data slice must stay stable while req is high and ack is low. req may drop only after an ack or before the grant.
- Throughput: max_burst words per max_burst+1 cycles with full=0.

Test Plan:
- Burst split: full=0; only req[1] high, 6 words A0..A5 -> IDLE 1 cycle; writes A0..A3 on 4 consecutive cycles with grant_id=1; 1 IDLE cycle; writes A4,A5; req drops -> IDLE with rr_ptr=2.
- Round-robin: req=4'b1111, each requester with unlimited words, full=0 -> grant order 0,1,2,3,0. Each grant writes 4 words with its own data, separated by one IDLE cycle; rr_ptr wraps 3->0.
- Full stall: grant to req 2 after 1 word; full=1 for 5 cycles -> write_cmd=0, ack=0, beat_count stays 1, grant_id stays 2. After full drops, 3 more words are written, then IDLE.
- Early release: req[3] granted, sends 2 words, drops req -> IDLE the next cycle, rr_ptr=0. A pending req[0] is granted next, ahead of req[1].
- Reset mid-burst: reset high for 1 cycle during a burst from req 1 with beat_count=2 -> next cycle grant_valid=0, grant_id=0, rr_ptr=0, write_cmd=0. req=4'b0110 then grants req 1 first.
- Skip pattern: rr_ptr=1, req=4'b1001 -> req 3 granted first, rr_ptr then 0, req 0 granted next.

Source files
------------

// File: rtl/queue_write_arbiter.sv
// Round-robin arbiter that shares one queue write port between num_req producers,
// granting bounded bursts and honouring the queue's full flag.
module queue_write_arbiter #(
  parameter int unsigned data_width   = 4,
  parameter int unsigned num_req      = 4,
  parameter int unsigned req_id_width = 2,
  parameter int unsigned max_burst    = 4,
  parameter int unsigned count_width  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_req-1:0]             req,
  input  logic [num_req*data_width-1:0]  req_data,
  output logic [num_req-1:0]             ack,
  input  logic                           full,
  output logic                           write_cmd,
  output logic [data_width-1:0]          write_data,
  output logic                           grant_valid,
  output logic [req_id_width-1:0]        grant_id
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [count_width-1:0]  LAST_BEAT = count_width'(max_burst - 1);
  localparam logic [req_id_width-1:0] LAST_REQ  = req_id_width'(num_req - 1);

  state_t                  state_q, state_d;
  logic [req_id_width-1:0] rr_ptr_q, rr_ptr_d;
  logic [req_id_width-1:0] grant_id_q, grant_id_d;
  logic [count_width-1:0]  beat_q, beat_d;

  logic [data_width-1:0]   slice [num_req];
  logic [req_id_width-1:0] next_ptr;
  logic [req_id_width-1:0] cand;
  logic [req_id_width-1:0] pick;
  logic                    pick_valid;

  for (genvar gi = 0; gi < int'(num_req); gi++) begin : g_slice
    assign slice[gi] = req_data[gi*data_width +: data_width];
  end

  assign write_data  = slice[grant_id_q];
  assign grant_valid = (state_q == BURST);
  assign grant_id    = grant_id_q;
  assign next_ptr    = (grant_id_q == LAST_REQ) ? '0 : grant_id_q + req_id_width'(1);

  // First requester at or after rr_ptr, wrapping modulo num_req.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int unsigned k = 0; k < num_req; k++) begin
      cand = req_id_width'((32'(rr_ptr_q) + k) % num_req);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_d     = beat_q;
    write_cmd  = 1'b0;
    ack        = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick;
          beat_d     = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        write_cmd       = req[grant_id_q] & ~full;
        ack[grant_id_q] = write_cmd;
        if (!req[grant_id_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (write_cmd) begin
          if (beat_q == LAST_BEAT) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end else begin
            beat_d = beat_q + count_width'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_q     <= beat_d;
    end
  end

endmodule

// File: tb/tb_queue_write_arbiter.sv
// Directed bench for queue_write_arbiter: producers are modelled as word counters,
// every cycle's expected grant/write/ack is written out by hand.
module tb_queue_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  ack;
  logic        full;
  logic        write_cmd;
  logic [3:0]  write_data;
  logic        grant_valid;
  logic [1:0]  grant_id;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          left [4];
  logic [3:0]  word [4];
  logic [3:0]  ack_cap;

  queue_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .full        (full),
    .write_cmd   (write_cmd),
    .write_data  (write_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i]             = (left[i] != 0);
      req_data[i*4 +: 4] = word[i];
    end
  endtask

  task automatic chk_outs(input string tag, input bit gv, input int gid, input bit wc, input int wd);
    logic [3:0] exp_ack;
    exp_ack = wc ? (4'b0001 << gid) : 4'b0000;
    check_eq({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
    check_eq({tag, ".grant_id"},    32'(grant_id),    32'(gid));
    check_eq({tag, ".write_cmd"},   32'(write_cmd),   32'(wc));
    check_eq({tag, ".ack"},         32'(ack),         32'(exp_ack));
    if (wc) check_eq({tag, ".write_data"}, 32'(write_data), 32'(wd));
  endtask

  // Check the current cycle, clock it, then let producers consume acked words.
  task automatic cyc(input string tag, input bit gv, input int gid, input bit wc, input int wd);
    #1;
    chk_outs(tag, gv, gid, wc, wd);
    ack_cap = ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (ack_cap[i]) begin
        word[i] = word[i] + 4'd1;
        left[i] = left[i] - 1;
      end
    end
    drive();
  endtask

  int         order [5] = '{0, 1, 2, 3, 0};
  logic [3:0] base  [5] = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h4};
  int         prev;

  initial begin
    reset = 1'b1;
    full  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      left[i] = 0;
      word[i] = '0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 0, 0);
    reset = 1'b0;

    // Burst split: six words from req 1 are split 4 + 2
    left[1] = 6; word[1] = 4'h8; drive();
    cyc("split_idle0", 0, 0, 0, 0);
    cyc("split_w0", 1, 1, 1, 8);
    cyc("split_w1", 1, 1, 1, 9);
    cyc("split_w2", 1, 1, 1, 10);
    cyc("split_w3", 1, 1, 1, 11);
    cyc("split_idle1", 0, 1, 0, 0);
    cyc("split_w4", 1, 1, 1, 12);
    cyc("split_w5", 1, 1, 1, 13);
    cyc("split_rel", 1, 1, 0, 0);
    cyc("split_idle2", 0, 1, 0, 0);
    // rr_ptr is 2: with req 1 and 2 pending, 2 wins, then 1
    left[1] = 1; word[1] = 4'hE; left[2] = 1; word[2] = 4'h5; drive();
    cyc("ptr2_idle", 0, 1, 0, 0);
    cyc("ptr2_g2", 1, 2, 1, 5);
    cyc("ptr2_rel2", 1, 2, 0, 0);
    cyc("ptr2_idle2", 0, 2, 0, 0);
    cyc("ptr2_g1", 1, 1, 1, 14);
    cyc("ptr2_rel1", 1, 1, 0, 0);
    cyc("ptr2_idle3", 0, 1, 0, 0);

    // Round robin with all four requesting
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_outs("reset2", 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      left[i] = 100;
      word[i] = 4'(i * 4);
    end
    drive();
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      cyc("rr_idle", 0, prev, 0, 0);
      for (int b = 0; b < 4; b++) cyc("rr_burst", 1, order[g], 1, int'(base[g]) + b);
      prev = order[g];
    end
    for (int i = 0; i < 4; i++) left[i] = 0;
    drive();
    cyc("rr_quiet", 0, 0, 0, 0);

    // Full stall mid-burst on req 2 (rr_ptr is 1)
    left[2] = 4; word[2] = 4'h3; drive();
    cyc("fs_idle", 0, 0, 0, 0);
    cyc("fs_w0", 1, 2, 1, 3);
    full = 1'b1; drive();
    for (int s = 0; s < 5; s++) cyc("fs_stall", 1, 2, 0, 0);
    full = 1'b0; drive();
    cyc("fs_w1", 1, 2, 1, 4);
    cyc("fs_w2", 1, 2, 1, 5);
    cyc("fs_w3", 1, 2, 1, 6);
    cyc("fs_end", 0, 2, 0, 0);

    // Early release by req 3; req 0 then beats req 1
    left[3] = 2; word[3] = 4'h9;
    left[0] = 1; word[0] = 4'h1;
    left[1] = 1; word[1] = 4'h2;
    drive();
    cyc("er_idle", 0, 2, 0, 0);
    cyc("er_w0", 1, 3, 1, 9);
    cyc("er_w1", 1, 3, 1, 10);
    cyc("er_rel3", 1, 3, 0, 0);
    cyc("er_idle3", 0, 3, 0, 0);
    cyc("er_g0", 1, 0, 1, 1);
    cyc("er_rel0", 1, 0, 0, 0);
    cyc("er_idle0", 0, 0, 0, 0);
    cyc("er_g1", 1, 1, 1, 2);
    cyc("er_rel1", 1, 1, 0, 0);
    cyc("er_idle1", 0, 1, 0, 0);

    // Reset mid-burst at beat 2; the word in the reset cycle is still acked
    left[1] = 10; word[1] = 4'h0; drive();
    cyc("rm_idle", 0, 1, 0, 0);
    cyc("rm_w0", 1, 1, 1, 0);
    cyc("rm_w1", 1, 1, 1, 1);
    reset = 1'b1;
    cyc("rm_w2_reset", 1, 1, 1, 2);
    reset = 1'b0;
    left[1] = 1; left[2] = 1; word[2] = 4'h7; drive();
    cyc("rm_post", 0, 0, 0, 0);
    cyc("rm_g1", 1, 1, 1, 3);
    cyc("rm_rel1", 1, 1, 0, 0);
    cyc("rm_idle1", 0, 1, 0, 0);
    cyc("rm_g2", 1, 2, 1, 7);
    cyc("rm_rel2", 1, 2, 0, 0);
    cyc("rm_idle2", 0, 2, 0, 0);

    // Skip pattern: move rr_ptr to 1, then req = 4'b1001
    left[0] = 1; word[0] = 4'hB; drive();
    cyc("sk_idle", 0, 2, 0, 0);
    cyc("sk_g0", 1, 0, 1, 11);
    cyc("sk_rel0", 1, 0, 0, 0);
    left[0] = 1; word[0] = 4'hC;
    left[3] = 1; word[3] = 4'hD;
    drive();
    cyc("sk_idle1", 0, 0, 0, 0);
    cyc("sk_g3", 1, 3, 1, 13);
    cyc("sk_rel3", 1, 3, 0, 0);
    cyc("sk_idle3", 0, 3, 0, 0);
    cyc("sk_g0b", 1, 0, 1, 12);
    cyc("sk_rel0b", 1, 0, 0, 0);
    cyc("sk_end", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
